// File: rtl/avalon_pio_multi.sv
// avalon_pio_multi: Avalon-MM general-purpose I/O slave.
//
// Drives a bank of outputs, samples a bank of board inputs through a synchroniser,
// captures input edges into a sticky register and raises a maskable level interrupt.
//
// Register map (32-bit words, unused upper bits read 0):
//   0 DATA_OUT  RW   output bank
//   1 DATA_IN   RO   synchronised inputs
//   2 EDGE_CAP  W1C  sticky edge flags
//   3 IRQ_MASK  RW   per-input interrupt enable
//   4 OUT_SET   WO   gpio_out |= writedata
//   5 OUT_CLR   WO   gpio_out &= ~writedata
//   6 ID        RO   {8'h50, 8'h10, OUT_W, IN_W}
//   7 reserved
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   address    word address
//   read       read strobe; readdata is valid the cycle after
//   readdata   registered read data, held until the next read
//   write      write strobe
//   writedata  write data
//   gpio_in    asynchronous board inputs
//   gpio_out   output bank
//   irq        active-high level interrupt (registered)
module avalon_pio_multi #(
  parameter int unsigned OUT_W       = 16,
  parameter int unsigned IN_W        = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 0,
  parameter logic [31:0] OUT_RESET   = 32'h0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             read,
  output logic [31:0]      readdata,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [IN_W-1:0]  gpio_in,
  output logic [OUT_W-1:0] gpio_out,
  output logic             irq
);

  localparam logic [2:0] AddrDataOut = 3'd0;
  localparam logic [2:0] AddrDataIn  = 3'd1;
  localparam logic [2:0] AddrEdgeCap = 3'd2;
  localparam logic [2:0] AddrIrqMask = 3'd3;
  localparam logic [2:0] AddrOutSet  = 3'd4;
  localparam logic [2:0] AddrOutClr  = 3'd5;
  localparam logic [2:0] AddrId      = 3'd6;

  localparam logic [7:0]  OutWByte = 8'(OUT_W);
  localparam logic [7:0]  InWByte  = 8'(IN_W);
  localparam logic [31:0] IdValue  = {8'h50, 8'h10, OutWByte, InWByte};

  // State
  logic [IN_W-1:0]  sync_chain [SYNC_STAGES];
  logic [IN_W-1:0]  sync_q;
  logic [IN_W-1:0]  prev_q;
  logic [IN_W-1:0]  edge_cap_q, edge_cap_d;
  logic [IN_W-1:0]  irq_mask_q, irq_mask_d;
  logic [OUT_W-1:0] gpio_out_q, gpio_out_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;

  // Write data trimmed to the bank widths; upper bits are intentionally dropped.
  logic [OUT_W-1:0] wdata_out;
  logic [IN_W-1:0]  wdata_in;
  logic             unused_wdata;

  assign wdata_out    = writedata[OUT_W-1:0];
  assign wdata_in     = writedata[IN_W-1:0];
  assign unused_wdata = ^writedata;

  // Input synchroniser: stage 0 samples the pins, the last stage is the usable value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_chain[i] <= '0;
      end
    end else begin
      sync_chain[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_chain[i] <= sync_chain[i-1];
      end
    end
  end

  assign sync_q = sync_chain[SYNC_STAGES-1];

  // Edge detection against last cycle's synchronised sample.
  logic [IN_W-1:0] rise, fall, edge_det;

  always_comb begin
    rise = sync_q & ~prev_q;
    fall = ~sync_q & prev_q;
    if (EDGE_MODE == 0) begin
      edge_det = rise;
    end else if (EDGE_MODE == 1) begin
      edge_det = fall;
    end else begin
      edge_det = rise | fall;
    end
  end

  // Next-state for the software-visible registers.
  always_comb begin
    gpio_out_d = gpio_out_q;
    irq_mask_d = irq_mask_q;
    if (write) begin
      case (address)
        AddrDataOut: gpio_out_d = wdata_out;
        AddrOutSet:  gpio_out_d = gpio_out_q | wdata_out;
        AddrOutClr:  gpio_out_d = gpio_out_q & ~wdata_out;
        AddrIrqMask: irq_mask_d = wdata_in;
        default:     ;
      endcase
    end
  end

  // Edge set is applied after the W1C clear so a coincident edge keeps the bit.
  logic [IN_W-1:0] cap_clr;

  always_comb begin
    cap_clr    = (write && (address == AddrEdgeCap)) ? wdata_in : '0;
    edge_cap_d = (edge_cap_q & ~cap_clr) | edge_det;
  end

  // Read mux uses the pre-write register values, giving read-before-write ordering.
  always_comb begin
    readdata_d = readdata_q;
    if (read) begin
      case (address)
        AddrDataOut: readdata_d = 32'(gpio_out_q);
        AddrDataIn:  readdata_d = 32'(sync_q);
        AddrEdgeCap: readdata_d = 32'(edge_cap_q);
        AddrIrqMask: readdata_d = 32'(irq_mask_q);
        AddrId:      readdata_d = IdValue;
        default:     readdata_d = 32'h0;
      endcase
    end
  end

  // Interrupt follows the register state by one cycle.
  assign irq_d = |(edge_cap_q & irq_mask_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q     <= '0;
      edge_cap_q <= '0;
      irq_mask_q <= '0;
      gpio_out_q <= OUT_RESET[OUT_W-1:0];
      readdata_q <= 32'h0;
      irq_q      <= 1'b0;
    end else begin
      prev_q     <= sync_q;
      edge_cap_q <= edge_cap_d;
      irq_mask_q <= irq_mask_d;
      gpio_out_q <= gpio_out_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign gpio_out = gpio_out_q;
  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_avalon_pio_multi.sv
// Self-checking bench for avalon_pio_multi: a rising-edge instance and a both-edge
// instance share the bus; a delay-line reference model predicts every output.
module tb_avalon_pio_multi;

  localparam int S = 2;

  logic        clk;
  logic        reset;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [5:0]  gin0, gin1;
  logic [15:0] gout0, gout1;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  int n_vec;
  int n_err;

  avalon_pio_multi #(.EDGE_MODE(0)) u_dut0 (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .read     (read),
    .readdata (rd0),
    .write    (write),
    .writedata(writedata),
    .gpio_in  (gin0),
    .gpio_out (gout0),
    .irq      (irq0)
  );

  avalon_pio_multi #(.EDGE_MODE(2)) u_dut1 (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .read     (read),
    .readdata (rd1),
    .write    (write),
    .writedata(writedata),
    .gpio_in  (gin1),
    .gpio_out (gout1),
    .irq      (irq1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, one slot per instance.
  logic [15:0] m_out  [2];
  logic [5:0]  m_cap  [2];
  logic [5:0]  m_mask [2];
  logic        m_irq  [2];
  logic [31:0] m_rd   [2];
  // hist[k][0] is the most recent pin sample; the synchronised value is S samples old.
  logic [5:0]  hist   [2][S+1];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_out[k]  = 16'h0;
      m_cap[k]  = 6'h0;
      m_mask[k] = 6'h0;
      m_irq[k]  = 1'b0;
      m_rd[k]   = 32'h0;
      for (int j = 0; j <= S; j++) hist[k][j] = 6'h0;
    end
  endtask

  task automatic compare_all();
    chk("gpio_out0", {16'h0, gout0}, {16'h0, m_out[0]});
    chk("gpio_out1", {16'h0, gout1}, {16'h0, m_out[1]});
    chk("irq0", {31'h0, irq0}, {31'h0, m_irq[0]});
    chk("irq1", {31'h0, irq1}, {31'h0, m_irq[1]});
    chk("readdata0", rd0, m_rd[0]);
    chk("readdata1", rd1, m_rd[1]);
  endtask

  // One clock: predict from pre-edge state, advance, then compare #1 after the edge.
  task automatic tick();
    logic [15:0] n_out  [2];
    logic [5:0]  n_cap  [2];
    logic [5:0]  n_mask [2];
    logic        n_irq  [2];
    logic [31:0] n_rd   [2];
    logic [5:0]  smp    [2];
    logic [5:0]  s, p, ev, clr;
    for (int k = 0; k < 2; k++) begin
      s  = hist[k][S-1];
      p  = hist[k][S];
      ev = (k == 0) ? (s & ~p) : (s ^ p);
      n_rd[k] = m_rd[k];
      if (read) begin
        case (address)
          3'd0:    n_rd[k] = {16'h0, m_out[k]};
          3'd1:    n_rd[k] = {26'h0, s};
          3'd2:    n_rd[k] = {26'h0, m_cap[k]};
          3'd3:    n_rd[k] = {26'h0, m_mask[k]};
          3'd6:    n_rd[k] = 32'h5010_1006;
          default: n_rd[k] = 32'h0;
        endcase
      end
      n_irq[k]  = |(m_cap[k] & m_mask[k]);
      clr       = (write && address == 3'd2) ? writedata[5:0] : 6'h0;
      n_cap[k]  = (m_cap[k] & ~clr) | ev;
      n_mask[k] = (write && address == 3'd3) ? writedata[5:0] : m_mask[k];
      n_out[k]  = m_out[k];
      if (write && address == 3'd0) n_out[k] = writedata[15:0];
      if (write && address == 3'd4) n_out[k] = m_out[k] | writedata[15:0];
      if (write && address == 3'd5) n_out[k] = m_out[k] & ~writedata[15:0];
      smp[k] = (k == 0) ? gin0 : gin1;
    end
    @(posedge clk);
    #1;
    if (!reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        m_out[k]  = n_out[k];
        m_cap[k]  = n_cap[k];
        m_mask[k] = n_mask[k];
        m_irq[k]  = n_irq[k];
        m_rd[k]   = n_rd[k];
        for (int j = S; j > 0; j--) hist[k][j] = hist[k][j-1];
        hist[k][0] = smp[k];
      end
    end
    compare_all();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1; read = 1'b0;
    tick();
    write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    address = a; read = 1'b1; write = 1'b0;
    tick();
    read = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    address = 3'd0; read = 1'b0; write = 1'b0; writedata = 32'h0;
    gin0 = 6'h0; gin1 = 6'h0;
    model_reset();
    #12;
    chk("reset_gpio_out", {16'h0, gout0}, 32'h0);
    chk("reset_irq", {31'h0, irq0}, 32'h0);
    chk("reset_readdata", rd0, 32'h0);
    reset = 1'b1;

    // ID and reset readback
    rd(3'd6);
    chk("id", rd0, 32'h5010_1006);
    rd(3'd0);
    chk("data_out_reset", rd0, 32'h0);

    // Write, set, clear, readback
    wr(3'd0, 32'h0000_00A5);
    chk("write_a5", {16'h0, gout0}, 32'h00A5);
    wr(3'd4, 32'hFFFF_0F00);
    chk("out_set", {16'h0, gout0}, 32'h0FA5);
    wr(3'd5, 32'h0000_0005);
    chk("out_clr", {16'h0, gout0}, 32'h0FA0);
    rd(3'd0);
    chk("readback", rd0, 32'h0000_0FA0);
    rd(3'd4);
    chk("out_set_reads0", rd0, 32'h0);

    // Rising capture after sync latency; falling edge ignored in mode 0
    gin0 = 6'h01;
    idle(2);
    rd(3'd1);
    chk("data_in_rise", rd0, 32'h1);
    rd(3'd2);
    chk("edge_cap_rise", rd0, 32'h1);
    gin0 = 6'h00;
    idle(4);
    rd(3'd2);
    chk("edge_cap_fall_ignored", rd0, 32'h1);

    // Interrupt mask, W1C, coincident edge with clear
    wr(3'd3, 32'h1);
    tick();
    chk("irq_set", {31'h0, irq0}, 32'h1);
    wr(3'd2, 32'h1);
    tick();
    chk("irq_cleared", {31'h0, irq0}, 32'h0);
    gin0 = 6'h01;
    idle(2);
    wr(3'd2, 32'h1);
    rd(3'd2);
    chk("edge_wins_w1c", rd0, 32'h1);
    chk("irq_after_coincident", {31'h0, irq0}, 32'h1);

    // Both-edge instance: rise, clear, then fall recaptures
    gin1 = 6'h08;
    idle(5);
    rd(3'd2);
    chk("both_rise", rd1, 32'h8);
    wr(3'd2, 32'h8);
    rd(3'd2);
    chk("both_cleared", rd1, 32'h0);
    gin1 = 6'h00;
    idle(4);
    rd(3'd2);
    chk("both_fall", rd1, 32'h8);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      address   = 3'($urandom_range(0, 7));
      read      = 1'($urandom % 2);
      write     = ($urandom % 3) == 0;
      writedata = $urandom;
      if ($urandom % 4 == 0) gin0 = 6'($urandom);
      if ($urandom % 4 == 0) gin1 = 6'($urandom);
      tick();
    end
    read = 1'b0; write = 1'b0;

    // Asynchronous reset between edges with a pending read
    wr(3'd0, 32'h0000_FFFF);
    gin0 = 6'h00;
    idle(4);
    gin0 = 6'h3F;
    idle(4);
    rd(3'd2);
    chk("cap_all_set", rd0, 32'h3F);
    #3;
    address = 3'd2; read = 1'b1;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_gpio_out", {16'h0, gout0}, 32'h0);
    chk("async_irq", {31'h0, irq0}, 32'h0);
    chk("async_readdata", rd0, 32'h0);
    tick();
    #3;
    reset = 1'b1;
    read = 1'b0;
    rd(3'd2);
    chk("cap_after_reset", rd0, 32'h0);
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/avalon_pio_multi.md
Name: avalon_pio_multi

Overview:
Parametrised successor to the single-register game PIO. It is an Avalon-MM slave that drives a bank of general-purpose outputs and samples a bank of board inputs (keys, switches). It adds register readback, atomic bit set/clear, input synchronisation, configurable edge capture and a maskable level interrupt toward the HPS. It sits between the HPS lightweight bridge and the FPGA-side user logic or board I/O.

Parameters:
OUT_W, 16, width of the output bank (1..32)
IN_W, 6, width of the input bank (1..32)
SYNC_STAGES, 2, synchroniser flops per input bit (2..4)
EDGE_MODE, 0, edge-capture mode: 0 rising, 1 falling, 2 both
OUT_RESET, 0, reset value of the output register (OUT_W bits)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
address  in  3  Avalon word address
read  in  1  Avalon read strobe
readdata  out  32  Avalon read data, registered
write  in  1  Avalon write strobe
writedata  in  32  Avalon write data
gpio_in  in  IN_W  asynchronous board inputs (keys/switches)
gpio_out  out  OUT_W  output bank to user logic/LEDs
irq  out  1  level interrupt, active-high

Behaviour:
- Reset (reset=0, asynchronous): gpio_out=OUT_RESET; readdata=0; irq=0; edge_cap=0; irq_mask=0; all sync flops=0; previous-sample register=0.
- Register map (32-bit words; unused upper bits read 0, write-ignored):
  0 DATA_OUT RW: gpio_out[OUT_W-1:0].
  1 DATA_IN RO: synchronised input value.
  2 EDGE_CAP R/W1C: a write clears every bit where writedata=1.
  3 IRQ_MASK RW, IN_W bits.
  4 OUT_SET WO: gpio_out |= writedata[OUT_W-1:0]; reads 0.
  5 OUT_CLR WO: gpio_out &= ~writedata[OUT_W-1:0]; reads 0.
  6 ID RO: {8'h50, 8'h10, OUT_W[7:0], IN_W[7:0]}.
  7 reserved: reads 0, writes ignored.
- Register writes take effect on the clk edge where write=1. The new value is visible on gpio_out the next cycle.
- Reads have fixed 1-cycle latency. readdata is registered on the edge where read=1 and holds its value until the next read.
- A read and a write to the same address in the same cycle returns the pre-write value.
- Inputs pass through a SYNC_STAGES-deep flop chain (sync_q). A previous-sample register prev holds last cycle's sync_q.
- Edge detection per bit:
  rise = sync_q & ~prev
  fall = ~sync_q & prev
  both = rise | fall
- A detected edge sets edge_cap[i], which is sticky until cleared.
- Same cycle edge on bit i and W1C of bit i: the set wins and the bit stays 1.
- Input latency: a gpio_in change is visible in DATA_IN after SYNC_STAGES+1 edges and in edge_cap after SYNC_STAGES+1 edges. The exact value is checked in the test plan.
- irq is registered: irq <= |(edge_cap & irq_mask), one cycle behind the register state. Clearing the mask or edge bits drops irq the cycle after the update.
- Reset asserted mid-operation immediately returns all state to reset values. A pending read issued in the same cycle is lost: readdata=0.
- Bits above OUT_W or IN_W in writedata are ignored. Parameter widths of 32 must be handled without width truncation errors.

Test Plan:
- Reset/ID: assert reset=0 then release; read addr 6 -> 0x5010_1006 (defaults); gpio_out=0x0000; irq=0; read addr 0 -> 0.
- Write/readback and set/clear: write 0x00A5 to addr 0 -> gpio_out=0x00A5 the next cycle. Write 0x0F00 to addr 4 -> 0x0FA5. Write 0x0005 to addr 5 -> 0x0FA0. Read addr 0 -> 0x0000_0FA0, one cycle after read.
- Input sync and rising capture (EDGE_MODE 0): gpio_in 0->0x01 -> DATA_IN=0x01 and edge_cap=0x01 after 3 clk edges. Falling 0x01->0 -> edge_cap unchanged at 0x01.
- Interrupt: write irq_mask=0x01 with edge_cap[0]=1 -> irq=1 one cycle later. Write 0x01 to addr 2 -> edge_cap=0, irq=0 one cycle later. Coincident new edge plus W1C -> edge_cap[0] stays 1, irq stays 1.
- EDGE_MODE 2 instance: pulse gpio_in[3] high for 5 cycles -> edge_cap[3]=1. Clear it, then drive the falling edge -> edge_cap[3]=1 again.
- Async reset mid-transfer: set gpio_out=0xFFFF and edge_cap=0x3F, then drop reset between clk edges -> outputs zero immediately, without waiting for clk. Read addr 2 after release -> 0.
